pn_token_gen: RTL and testbench

- Transmitter end of the Polish-notation token interface.
- Buffers 2-4 operation groups loaded over a valid/ready port, then serializes them as the mode/operator/in/in_valid token stream the PN evaluator consumes.
- Then waits for the evaluator's out_valid burst, counts the results and captures them.
- Used as the on-chip stimulus/self-check source in front of the PN evaluator.

---
 rtl/pn_token_gen.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pn_token_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_token_gen.sv
// rtl/pn_token_gen.sv - Polish-notation token stream generator with result capture
//
// Buffers up to MAX_GRP (op, a, b) groups, emits them as a mode/operator/in
// token stream in one of four orders, then captures the evaluator's results.
//
// Ports:
//   clk, rst_n                   clock; synchronous reset, asserted when 1
//   grp_valid/grp_ready          group load handshake (grp_op, grp_a, grp_b)
//   start, start_mode            begin transmission, token order select
//   mode, operator, in, in_valid token stream towards the evaluator
//   res_valid, res_data          evaluator results
//   res0..res3, res_cnt          captured results and their count
//   busy, done, err              status: active, end pulse, error pulse
module pn_token_gen #(
  parameter int MAX_GRP = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               grp_valid,
  output logic               grp_ready,
  input  logic [2:0]         grp_op,
  input  logic [2:0]         grp_a,
  input  logic [2:0]         grp_b,
  input  logic               start,
  input  logic [1:0]         start_mode,
  output logic [1:0]         mode,
  output logic               operator,
  output logic [2:0]         in,
  output logic               in_valid,
  input  logic               res_valid,
  input  logic signed [31:0] res_data,
  output logic signed [31:0] res0,
  output logic signed [31:0] res1,
  output logic signed [31:0] res2,
  output logic signed [31:0] res3,
  output logic [2:0]         res_cnt,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_op [4];
  logic [2:0]         r_a  [4];
  logic [2:0]         r_b  [4];
  logic [2:0]         r_cnt;
  logic [2:0]         r_k;
  logic [2:0]         r_exp;
  logic [1:0]         r_mode;
  logic [3:0]         r_idx;
  logic [TW-1:0]      r_timer;
  logic [1:0]         r_mode_o;
  logic               r_operator;
  logic [2:0]         r_in;
  logic               r_in_valid;
  logic signed [31:0] r_res [4];
  logic [2:0]         r_res_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic       w_ready;
  logic       w_load;
  logic [2:0] w_k;
  logic [1:0] w_m;
  logic [3:0] w_j;
  logic [3:0] w_ntok;
  logic       w_last;
  logic       w_take;
  logic [2:0] w_got;
  logic [2:0] w_nop [4];
  logic [2:0] w_na  [4];
  logic [2:0] w_nb  [4];
  logic [1:0] w_q;
  logic [1:0] w_p;
  logic [1:0] w_t;
  logic       w_tok_opr;
  logic [2:0] w_tok_val;

  assign w_ready = (r_state == S_IDLE) && (r_cnt < 3'(MAX_GRP));
  assign w_load  = grp_valid && w_ready;
  // A group loaded in the same cycle as start counts toward k.
  assign w_k     = (r_state == S_IDLE) ? (r_cnt + {2'b00, w_load}) : r_k;
  assign w_m     = (r_state == S_IDLE) ? start_mode : r_mode;
  // Index of the token to register next: token 0 on start, else the successor.
  assign w_j     = (r_state == S_IDLE) ? 4'd0 : (r_idx + 4'd1);
  assign w_ntok  = w_m[1] ? {w_k, 1'b1} : ({w_k, 1'b0} + {1'b0, w_k});
  assign w_last  = (r_idx == (w_ntok - 4'd1));
  assign w_take  = res_valid && (r_res_cnt < r_exp);
  assign w_got   = r_res_cnt + {2'b00, w_take};

  // Token decode reads the buffer as it will be after this cycle's load, so a
  // group written alongside start is already visible to token 0.
  always_comb begin
    w_nop = r_op;
    w_na  = r_a;
    w_nb  = r_b;
    if (w_load) begin
      w_nop[r_cnt[1:0]] = grp_op;
      w_na[r_cnt[1:0]]  = grp_a;
      w_nb[r_cnt[1:0]]  = grp_b;
    end
    w_tok_opr = 1'b0;
    w_tok_val = 3'd0;
    w_q       = 2'(w_j / 4'd3);
    w_p       = 2'(w_j % 4'd3);
    w_t       = 2'd0;
    case (w_m)
      2'd0: begin
        case (w_p)
          2'd0:    begin w_tok_opr = 1'b1; w_tok_val = w_nop[w_q]; end
          2'd1:    w_tok_val = w_na[w_q];
          default: w_tok_val = w_nb[w_q];
        endcase
      end
      2'd1: begin
        case (w_p)
          2'd0:    w_tok_val = w_na[w_q];
          2'd1:    w_tok_val = w_nb[w_q];
          default: begin w_tok_opr = 1'b1; w_tok_val = w_nop[w_q]; end
        endcase
      end
      2'd2: begin
        // Operators outermost first, then x0 = a_0 and the b operands.
        if (w_j < {1'b0, w_k}) begin
          w_t       = 2'({1'b0, w_k} - 4'd1 - w_j);
          w_tok_opr = 1'b1;
          w_tok_val = w_nop[w_t];
        end else if (w_j == {1'b0, w_k}) begin
          w_tok_val = w_na[0];
        end else begin
          w_t       = 2'(w_j - {1'b0, w_k} - 4'd1);
          w_tok_val = w_nb[w_t];
        end
      end
      default: begin
        // a_0, then alternating b_g (odd index) and op_g (even index).
        if (w_j == 4'd0) begin
          w_tok_val = w_na[0];
        end else if (w_j[0]) begin
          w_tok_val = w_nb[w_j[2:1]];
        end else begin
          w_t       = 2'(w_j[3:1] - 3'd1);
          w_tok_opr = 1'b1;
          w_tok_val = w_nop[w_t];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_k        <= 3'd0;
      r_exp      <= 3'd0;
      r_mode     <= 2'd0;
      r_idx      <= 4'd0;
      r_timer    <= '0;
      r_mode_o   <= 2'd0;
      r_operator <= 1'b0;
      r_in       <= 3'd0;
      r_in_valid <= 1'b0;
      r_res_cnt  <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_op[i]  <= 3'd0;
        r_a[i]   <= 3'd0;
        r_b[i]   <= 3'd0;
        r_res[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_load) begin
        r_op[r_cnt[1:0]] <= grp_op;
        r_a[r_cnt[1:0]]  <= grp_a;
        r_b[r_cnt[1:0]]  <= grp_b;
        r_cnt            <= r_cnt + 3'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_k >= 3'd2) begin
              r_state    <= S_EMIT;
              r_mode     <= start_mode;
              r_k        <= w_k;
              r_exp      <= start_mode[1] ? 3'd1 : w_k;
              r_idx      <= 4'd0;
              r_in_valid <= 1'b1;
              r_mode_o   <= start_mode;
              r_operator <= w_tok_opr;
              r_in       <= w_tok_val;
              r_busy     <= 1'b1;
              r_res_cnt  <= 3'd0;
              for (int i = 0; i < 4; i++) r_res[i] <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (w_last) begin
            r_state    <= S_WAIT;
            r_in_valid <= 1'b0;
            r_mode_o   <= 2'd0;
            r_operator <= 1'b0;
            r_in       <= 3'd0;
            r_timer    <= '0;
          end else begin
            r_idx      <= r_idx + 4'd1;
            r_operator <= w_tok_opr;
            r_in       <= w_tok_val;
          end
        end
        S_WAIT: begin
          if (w_take) begin
            r_res[r_res_cnt[1:0]] <= res_data;
            r_res_cnt             <= w_got;
          end
          r_timer <= r_timer + 1'b1;
          // Completion is tested before expiry so a last-cycle result wins.
          if (w_got == r_exp) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign grp_ready = w_ready;
  assign mode      = r_mode_o;
  assign operator  = r_operator;
  assign in        = r_in;
  assign in_valid  = r_in_valid;
  assign res0      = r_res[0];
  assign res1      = r_res[1];
  assign res2      = r_res[2];
  assign res3      = r_res[3];
  assign res_cnt   = r_res_cnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_pn_token_gen.sv
// tb/tb_pn_token_gen.sv - self-checking bench for pn_token_gen
module tb_pn_token_gen;

  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               grp_valid;
  logic               grp_ready;
  logic [2:0]         grp_op;
  logic [2:0]         grp_a;
  logic [2:0]         grp_b;
  logic               start;
  logic [1:0]         start_mode;
  logic [1:0]         mode;
  logic               operator;
  logic [2:0]         in;
  logic               in_valid;
  logic               res_valid;
  logic signed [31:0] res_data;
  logic signed [31:0] res0, res1, res2, res3;
  logic [2:0]         res_cnt;
  logic               busy;
  logic               done;
  logic               err;

  always #5 clk = ~clk;

  pn_token_gen #(.MAX_GRP(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .grp_valid(grp_valid), .grp_ready(grp_ready),
    .grp_op(grp_op), .grp_a(grp_a), .grp_b(grp_b),
    .start(start), .start_mode(start_mode),
    .mode(mode), .operator(operator), .in(in), .in_valid(in_valid),
    .res_valid(res_valid), .res_data(res_data),
    .res0(res0), .res1(res1), .res2(res2), .res3(res3),
    .res_cnt(res_cnt), .busy(busy), .done(done), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the loaded groups and the expected token list {opr, val}.
  logic [2:0] mdl_op[$];
  logic [2:0] mdl_a[$];
  logic [2:0] mdl_b[$];
  logic [3:0] exp_tok[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    mdl_op.delete(); mdl_a.delete(); mdl_b.delete();
  endtask

  task automatic build_tok(input int m);
    int k;
    k = mdl_op.size();
    exp_tok.delete();
    case (m)
      0: for (int g = 0; g < k; g++) begin
           exp_tok.push_back({1'b1, mdl_op[g]});
           exp_tok.push_back({1'b0, mdl_a[g]});
           exp_tok.push_back({1'b0, mdl_b[g]});
         end
      1: for (int g = 0; g < k; g++) begin
           exp_tok.push_back({1'b0, mdl_a[g]});
           exp_tok.push_back({1'b0, mdl_b[g]});
           exp_tok.push_back({1'b1, mdl_op[g]});
         end
      2: begin
           for (int g = k - 1; g >= 0; g--) exp_tok.push_back({1'b1, mdl_op[g]});
           exp_tok.push_back({1'b0, mdl_a[0]});
           for (int g = 0; g < k; g++) exp_tok.push_back({1'b0, mdl_b[g]});
         end
      default: begin
           exp_tok.push_back({1'b0, mdl_a[0]});
           for (int g = 0; g < k; g++) begin
             exp_tok.push_back({1'b0, mdl_b[g]});
             exp_tok.push_back({1'b1, mdl_op[g]});
           end
         end
    endcase
  endtask

  function automatic logic [31:0] res_at(input int j);
    case (j)
      0: return res0;
      1: return res1;
      2: return res2;
      default: return res3;
    endcase
  endfunction

  task automatic load(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    logic rdy_exp;
    rdy_exp = (mdl_op.size() < 4);
    chk("grp_ready", {31'd0, grp_ready}, {31'd0, rdy_exp});
    grp_valid = 1'b1; grp_op = op; grp_a = a; grp_b = b;
    @(negedge clk);
    grp_valid = 1'b0;
    if (rdy_exp) begin
      mdl_op.push_back(op); mdl_a.push_back(a); mdl_b.push_back(b);
    end
  endtask

  task automatic load_rand();
    load(3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  // Start in mode m, check exp_tok, feed nfeed random results, check capture.
  task automatic run(input logic [1:0] m, input int nfeed);
    int nexp, ncap, cyc;
    logic [31:0] rv[$];
    logic [31:0] v;
    nexp = (m < 2) ? mdl_op.size() : 1;
    start = 1'b1; start_mode = m;
    @(negedge clk);
    start = 1'b0; grp_valid = 1'b0;
    chk("res_cnt_clr", {29'd0, res_cnt}, 32'd0);
    chk("busy_emit", {31'd0, busy}, 32'd1);
    foreach (exp_tok[i]) begin
      chk("in_valid", {31'd0, in_valid}, 32'd1);
      chk("mode", {30'd0, mode}, {30'd0, m});
      chk("operator", {31'd0, operator}, {31'd0, exp_tok[i][3]});
      chk("in", {29'd0, in}, {29'd0, exp_tok[i][2:0]});
      @(negedge clk);
    end
    chk("in_valid_end", {31'd0, in_valid}, 32'd0);
    chk("mode_idle", {30'd0, mode}, 32'd0);
    for (int i = 0; i < nfeed; i++) begin
      v = $urandom;
      rv.push_back(v);
      res_valid = 1'b1; res_data = v;
      @(negedge clk);
    end
    res_valid = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    ncap = (nfeed < nexp) ? nfeed : nexp;
    chk("done", {31'd0, done}, 32'd1);
    chk("done_latency", cyc, (nfeed < nexp) ? (TIMEOUT - nfeed) : 0);
    chk("err", {31'd0, err}, {31'd0, (nfeed < nexp)});
    chk("res_cnt", {29'd0, res_cnt}, ncap);
    for (int j = 0; j < ncap; j++) chk("res_val", res_at(j), rv[j]);
    chk("busy_done", {31'd0, busy}, 32'd0);
    // A result outside WAIT_RES must be ignored.
    res_valid = 1'b1; res_data = $urandom;
    @(negedge clk);
    res_valid = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("err_pulse", {31'd0, err}, 32'd0);
    chk("res_cnt_hold", {29'd0, res_cnt}, ncap);
    if (ncap > 0) chk("res0_hold", res0, rv[0]);
    chk("grp_ready_after", {31'd0, grp_ready}, 32'd1);
    mdl_clear();
  endtask

  initial begin
    rst_n = 1'b1; grp_valid = 1'b0; grp_op = '0; grp_a = '0; grp_b = '0;
    start = 1'b0; start_mode = '0; res_valid = 1'b0; res_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_valid", {31'd0, in_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_res_cnt", {29'd0, res_cnt}, 32'd0);
    chk("rst_res0", res0, 32'd0);
    chk("rst_mode", {30'd0, mode}, 32'd0);
    chk("rst_grp_ready", {31'd0, grp_ready}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);

    // Directed orders on (0,3,2),(2,1,4).
    load(3'd0, 3'd3, 3'd2); load(3'd2, 3'd1, 3'd4);
    exp_tok = '{4'b1000, 4'b0011, 4'b0010, 4'b1010, 4'b0001, 4'b0100};
    run(2'd0, 2);
    load(3'd0, 3'd3, 3'd2); load(3'd2, 3'd1, 3'd4);
    exp_tok = '{4'b1010, 4'b1000, 4'b0011, 4'b0010, 4'b0100};
    run(2'd2, 1);
    load(3'd0, 3'd3, 3'd2); load(3'd2, 3'd1, 3'd4);
    exp_tok = '{4'b0011, 4'b0010, 4'b1000, 4'b0100, 4'b1010};
    run(2'd3, 1);

    // Full buffer: fifth group refused.
    repeat (4) load_rand();
    chk("grp_ready_full", {31'd0, grp_ready}, 32'd0);
    load_rand();
    build_tok(1);
    run(2'd1, 4);

    // Illegal start with one group, then a start with a same-cycle load.
    load_rand();
    start = 1'b1; start_mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_in_valid", {31'd0, in_valid}, 32'd0);
    chk("illegal_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("illegal_err_pulse", {31'd0, err}, 32'd0);
    grp_valid = 1'b1; grp_op = 3'd3; grp_a = 3'd5; grp_b = 3'd6;
    mdl_op.push_back(3'd3); mdl_a.push_back(3'd5); mdl_b.push_back(3'd6);
    build_tok(0);
    run(2'd0, 2);

    // Timeout with a missing result; the following start clears res_cnt.
    repeat (3) load_rand();
    build_tok(0);
    run(2'd0, 2);

    // Final result on the expiry cycle wins over the timeout.
    repeat (2) load_rand();
    build_tok(2);
    start = 1'b1; start_mode = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (exp_tok.size()) @(negedge clk);
    chk("race_in_valid", {31'd0, in_valid}, 32'd0);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("race_not_done", {31'd0, done}, 32'd0);
    res_valid = 1'b1; res_data = 32'h1234_5678;
    @(negedge clk);
    res_valid = 1'b0;
    chk("race_done", {31'd0, done}, 32'd1);
    chk("race_err", {31'd0, err}, 32'd0);
    chk("race_res0", res0, 32'h1234_5678);
    chk("race_res_cnt", {29'd0, res_cnt}, 32'd1);
    @(negedge clk);
    mdl_clear();

    // Reset during the fourth token.
    repeat (2) load_rand();
    build_tok(0);
    start = 1'b1; start_mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst_in", {29'd0, in}, {29'd0, exp_tok[i][2:0]});
      @(negedge clk);
    end
    chk("pre_rst_in_valid", {31'd0, in_valid}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("mid_rst_in_valid", {31'd0, in_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_grp_ready", {31'd0, grp_ready}, 32'd1);
    mdl_clear();
    load_rand();
    start = 1'b1; start_mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk("mid_rst_count0_err", {31'd0, err}, 32'd1);
    chk("mid_rst_no_emit", {31'd0, in_valid}, 32'd0);
    @(negedge clk);
    load_rand();
    build_tok(0);
    run(2'd0, 2);

    // Randomised transactions.
    for (int t = 0; t < 12; t++) begin
      int k;
      int m;
      k = $urandom_range(2, 4);
      m = $urandom_range(0, 3);
      repeat (k) load_rand();
      build_tok(m);
      run(2'(m), (m < 2) ? k : 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
